// File: rtl/sm_muldiv.sv
// sm_muldiv: iterative multiply/divide unit with HI/LO result registers.
// One result bit per cycle (shift-add multiply, restoring divide).
// The FSM state is held in the named signal `state` (type state_t) so a
// checker can bind to it directly.
//
// Handshake: `start` is accepted on any rising edge where busy=0 (IDLE or
// DONE). `busy` stays high from the cycle after the accepted start until the
// result is written. `done` is high for exactly one cycle, and hi/lo already
// hold the result in that cycle. A second start while busy=1 is dropped. It
// is not queued.
module sm_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             abort,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t state, stateNext;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   acc;      // mul: {partial sum, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   bReg;     // |multiplicand| or |divisor|
  logic               isDiv;
  logic               negRes;   // product / quotient must be negated
  logic               negRem;   // remainder takes the dividend's sign

  logic               accepted;
  logic               divZero;
  logic               aNeg, bNeg;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH:0]   mulNext;
  logic [2*WIDTH:0]   divShift;
  logic [WIDTH+1:0]   divTrial;
  logic [2*WIDTH:0]   divNext;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix, remFix;

  // Operand magnitudes and one iteration step for both operation kinds
  always_comb begin
    accepted = start && !busy;
    divZero  = op[1] && (srcB == '0);
    aNeg     = op[0] && srcA[WIDTH-1];
    bNeg     = op[0] && srcB[WIDTH-1];
    absA     = aNeg ? (~srcA + 1'b1) : srcA;
    absB     = bNeg ? (~srcB + 1'b1) : srcB;

    // Shift-add: add multiplicand into the upper half when the low bit is set, then shift right.
    mulSum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, bReg} : '0);
    mulNext  = {1'b0, mulSum, acc[WIDTH-1:1]};

    // Restoring divide: shift left, trial subtract, keep the difference when it does not borrow.
    divShift = {acc[2*WIDTH-1:0], 1'b0};
    divTrial = {1'b0, divShift[2*WIDTH:WIDTH]} - {2'b00, bReg};
    divNext  = divTrial[WIDTH+1] ? divShift
                                 : {divTrial[WIDTH:0], divShift[WIDTH-1:1], 1'b1};

    // Sign correction applied in FIX; MIN/-1 falls out naturally as quotient MIN, remainder 0.
    prodFix  = negRes ? (~acc[2*WIDTH-1:0] + 1'b1) : acc[2*WIDTH-1:0];
    quoFix   = negRes ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    remFix   = negRem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state and status outputs
  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        done      = (state == DONE);
        stateNext = IDLE;
        if (start) stateNext = divZero ? DONE : ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (abort)                  stateNext = IDLE;
        else if (cnt == LAST_STEP)  stateNext = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        stateNext = abort ? IDLE : DONE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, result write-back and MTHI/MTLO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      bReg   <= '0;
      cnt    <= '0;
      isDiv  <= 1'b0;
      negRes <= 1'b0;
      negRem <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (wr_hi && !busy) hi <= wd;
      if (wr_lo && !busy) lo <= wd;
      if (accepted) begin
        acc    <= {{(WIDTH+1){1'b0}}, absA};
        bReg   <= absB;
        cnt    <= '0;
        isDiv  <= op[1];
        negRes <= aNeg ^ bNeg;
        negRem <= aNeg;
        dz     <= divZero;
        // Divide by zero completes immediately; overrides a same-cycle MTHI/MTLO.
        if (divZero) begin
          hi <= srcA;
          lo <= '1;
        end
      end else if (state == ITER) begin
        acc <= isDiv ? divNext : mulNext;
        cnt <= cnt + 1'b1;
      end else if (state == FIX && !abort) begin
        if (isDiv) begin
          hi <= remFix;
          lo <= quoFix;
        end else begin
          hi <= prodFix[2*WIDTH-1:WIDTH];
          lo <= prodFix[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_sm_muldiv.sv
// tb_sm_muldiv: directed vectors for sm_muldiv (WIDTH=32) with hand-computed results.
module tb_sm_muldiv;

  localparam int W = 32;
  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] srcA, srcB;
  logic         abort;
  logic         wr_hi, wr_lo;
  logic [W-1:0] wd;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  sm_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .abort(abort), .wr_hi(wr_hi), .wr_lo(wr_lo), .wd(wd),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog in case something blocks outside the bounded loops
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sample from cycle `first` until done, bounded; reports latency and whether busy stayed high.
  task automatic waitDone(input int first, output int lat, output bit busyOk);
    lat = first;
    busyOk = 1'b1;
    while (!done && lat < 200) begin
      if (!busy) busyOk = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eHi, input logic [W-1:0] eLo,
                       input logic eDz, input int eLat);
    int lat;
    bit busyOk;
    launch(o, a, b);
    waitDone(1, lat, busyOk);
    check({tag, "_lat"}, 64'(lat), 64'(eLat));
    check({tag, "_busy_run"}, 64'(busyOk), 64'd1);
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(eHi));
    check({tag, "_lo"}, 64'(lo), 64'(eLo));
    check({tag, "_dz"}, 64'(dz), 64'(eDz));
  endtask

  // Count done pulses over n cycles
  task automatic countDone(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (done) cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    bit busyOk;
    int nDone;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
    abort = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wd = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(dz), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiply
    runOp("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34);
    runOp("mult_m3x7", MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34);
    runOp("mult_min", MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 34);

    // Divide
    runOp("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
    runOp("div_m7_2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
    runOp("div_7_m2", DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 34);
    runOp("div_min_m1", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34);

    // Divide by zero, then dz cleared by the next start
    runOp("divu_5_0", DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1);
    launch(MULTU, 32'd2, 32'd3);
    check("dz_clear_c1", 64'(dz), 64'd0);
    waitDone(1, lat, busyOk);
    check("mul_2x3_lat", 64'(lat), 64'd34);
    check("mul_2x3_lo", 64'(lo), 64'd6);

    // MTLO in the DONE cycle lands
    wr_lo = 1'b1; wd = 32'h0000BEEF;
    @(negedge clk);
    wr_lo = 1'b0;
    check("mtlo_done", 64'(lo), 64'h0000BEEF);

    // MTHI while idle
    wr_hi = 1'b1; wd = 32'hA5A5A5A5;
    @(negedge clk);
    wr_hi = 1'b0;
    check("mthi_idle", 64'(hi), 64'hA5A5A5A5);

    // Start + MTHI at cycle 10 of a running op are both ignored
    launch(MULTU, 32'h10, 32'h10);
    repeat (9) @(negedge clk);
    start = 1'b1; op = DIVU; srcA = 32'd9; srcB = 32'd0; wr_hi = 1'b1; wd = 32'h1234;
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0;
    check("busy_wr_hi_ignored", 64'(hi), 64'hA5A5A5A5);
    waitDone(11, lat, busyOk);
    check("busy_start_lat", 64'(lat), 64'd34);
    check("busy_start_hi", 64'(hi), 64'h0);
    check("busy_start_lo", 64'(lo), 64'h100);
    check("busy_start_dz", 64'(dz), 64'd0);
    @(negedge clk);

    // Abort at cycle 10: idle next cycle, hi/lo untouched, no done ever
    launch(MULTU, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'h0);
    check("abort_lo", 64'(lo), 64'h100);
    countDone(40, nDone);
    check("abort_no_done", 64'(nDone), 64'd0);
    check("abort_lo_later", 64'(lo), 64'h100);

    // Abort together with start in IDLE: start wins
    abort = 1'b1;
    launch(MULTU, 32'd11, 32'd13);
    abort = 1'b0;
    waitDone(1, lat, busyOk);
    check("abort_start_lat", 64'(lat), 64'd34);
    check("abort_start_lo", 64'(lo), 64'd143);

    // Back-to-back start in the DONE cycle
    launch(MULTU, 32'd7, 32'd9);
    waitDone(1, lat, busyOk);
    check("b2b_first_lo", 64'(lo), 64'd63);
    check("b2b_first_done", 64'(done), 64'd1);
    launch(MULT, 32'hFFFFFFFF, 32'd5);
    waitDone(1, lat, busyOk);
    check("b2b_second_lat", 64'(lat), 64'd34);
    check("b2b_second_busy", 64'(busyOk), 64'd1);
    check("b2b_second_hi", 64'(hi), 64'hFFFFFFFF);
    check("b2b_second_lo", 64'(lo), 64'hFFFFFFFB);
    @(negedge clk);

    // Reset at cycle 5 of a DIVU
    launch(DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    countDone(40, nDone);
    check("rst_mid_no_done", 64'(nDone), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
